// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// controller states, default operand width and product width helper.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    localparam int DEFAULT_W = 4;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: dout = neg ? -din : din.
module cond_negate #(
    parameter int N = 4
) (
    input  logic         neg,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule

// File: rtl/seq_array_mul.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, signed or
// unsigned operands, valid/ready handshakes on both sides.
module seq_array_mul
    import seq_mul_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    input  logic                     signed_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_width(W)-1:0] p,
    output logic                     busy
);

    localparam int PW = prod_width(W);
    localparam logic [W-1:0] LAST = W'(W - 1);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   count_q;
    logic [W-1:0]   mcand_q;
    logic [PW:0]    acc_q;
    logic           neg_q;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [PW-1:0]  p_final;
    logic [W:0]     partial;

    // Operand magnitudes; |-2^(W-1)| still fits in W unsigned bits.
    cond_negate #(.N(W)) u_abs_a (
        .neg  (signed_mode & a[W-1]),
        .din  (a),
        .dout (mag_a)
    );

    cond_negate #(.N(W)) u_abs_b (
        .neg  (signed_mode & b[W-1]),
        .din  (b),
        .dout (mag_b)
    );

    cond_negate #(.N(PW)) u_fix_sign (
        .neg  (neg_q),
        .din  (acc_q[PW-1:0]),
        .dout (p_final)
    );

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        partial = acc_q[PW:W];
        // acc_q[0] is the current multiplier bit; the multiplier shifts out as the product shifts in.
        if (acc_q[0]) begin
            partial = acc_q[PW:W] + {1'b0, mcand_q};
        end
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (count_q == LAST) state_d = SIGN;
            SIGN:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == DONE);
            busy      <= (state_d == CALC) || (state_d == SIGN);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= mag_a;
                        acc_q   <= {1'b0, {W{1'b0}}, mag_b};
                        neg_q   <= signed_mode & (a[W-1] ^ b[W-1]);
                        count_q <= '0;
                    end
                end
                CALC: begin
                    acc_q   <= {1'b0, partial, acc_q[W-1:1]};
                    count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
                end
                SIGN: begin
                    p <= p_final;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_mul.sv
// Directed and exhaustive checks of seq_array_mul at W=4 plus a W=8 regression.
module tb_seq_array_mul;

    logic       clk;
    logic       rst;

    logic       in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int errors;
    int checks;

    seq_array_mul #(.W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .a           (a4),
        .b           (b4),
        .signed_mode (sm4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .p           (p4),
        .busy        (busy4)
    );

    seq_array_mul #(.W(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .p           (p8),
        .busy        (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one W=4 operation from a negedge and returns at the negedge after the output handshake.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic sm,
                                 input int stall, output logic [7:0] prod, output int lat,
                                 output int ready_leak);
        int wait_cyc;
        wait_cyc   = 0;
        ready_leak = 0;
        while (!in_ready4 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        checkOutput("idle_reached", {31'd0, in_ready4}, 32'd1);
        a4 = av; b4 = bv; sm4 = sm; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b0;
        a4 = ~av; b4 = ~bv; sm4 = ~sm;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            if (in_ready4) ready_leak++;
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < stall; i++) begin
            if (in_ready4) ready_leak++;
            @(negedge clk);
        end
        prod = p4;
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    task automatic applyStimulusWide(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                                     output logic [15:0] prod, output int lat, output int busy_seen);
        a8 = av; b8 = bv; sm8 = sm; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        busy_seen = 0;
        while (!out_valid8 && lat < 40) begin
            if (busy8) busy_seen++;
            @(negedge clk);
            lat++;
        end
        prod = p8;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    initial begin
        logic [7:0]  prod;
        logic [15:0] prod8;
        logic [7:0]  exp;
        int lat, leak, bad, busy_cnt;

        errors = 0; checks = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; sm4 = 0;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; sm8 = 0;
        rst = 1'b1;
        #12;
        checkOutput("rst_in_ready", {31'd0, in_ready4}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy4}, 32'd0);
        checkOutput("rst_p", {24'd0, p4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] unsigned 15x15");
        applyStimulus(4'hF, 4'hF, 1'b0, 0, prod, lat, leak);
        checkOutput("u15x15_p", {24'd0, prod}, 32'hE1);
        checkOutput("u15x15_latency", lat, 5);
        checkOutput("u15x15_ready_low", leak, 0);
        checkOutput("u15x15_valid_cleared", {31'd0, out_valid4}, 32'd0);
        checkOutput("u15x15_ready_back", {31'd0, in_ready4}, 32'd1);
        checkOutput("u15x15_p_held", {24'd0, p4}, 32'hE1);

        $display("[TB] signed corner cases");
        applyStimulus(4'h8, 4'h8, 1'b1, 1, prod, lat, leak);
        checkOutput("s_m8xm8", {24'd0, prod}, 32'h40);
        applyStimulus(4'hD, 4'h5, 1'b1, 0, prod, lat, leak);
        checkOutput("s_m3x5", {24'd0, prod}, 32'hF1);
        applyStimulus(4'h0, 4'h8, 1'b1, 2, prod, lat, leak);
        checkOutput("s_0xm8", {24'd0, prod}, 32'h00);
        checkOutput("s_0xm8_latency", lat, 5);

        $display("[TB] backpressure 7x6");
        a4 = 4'h7; b4 = 4'h6; sm4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", lat, 5);
        bad = 0;
        a4 = 4'h1; b4 = 4'h1; in_valid4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (p4 !== 8'h2A || out_valid4 !== 1'b1 || in_ready4 !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("bp_stable", bad, 0);
        checkOutput("bp_p", {24'd0, p4}, 32'h2A);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        checkOutput("bp_idle_after", {31'd0, in_ready4}, 32'd1);
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_held_op_p", {24'd0, p4}, 32'h01);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;

        $display("[TB] reset during CALC");
        a4 = 4'h7; b4 = 4'h6; sm4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy4}, 32'd0);
        checkOutput("mid_rst_p", {24'd0, p4}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready4}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(4'h3, 4'h3, 1'b0, 0, prod, lat, leak);
        checkOutput("post_rst_3x3", {24'd0, prod}, 32'h09);
        checkOutput("post_rst_latency", lat, 5);

        $display("[TB] exhaustive W=4");
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    logic [3:0] ai, bj;
                    ai = 4'(i);
                    bj = 4'(j);
                    if (m == 1)
                        exp = 8'($signed({{4{ai[3]}}, ai}) * $signed({{4{bj[3]}}, bj}));
                    else
                        exp = {4'd0, ai} * {4'd0, bj};
                    applyStimulus(ai, bj, m[0], int'($urandom_range(0, 2)), prod, lat, leak);
                    checkOutput($sformatf("exh_m%0d_%0h_%0h", m, ai, bj), {24'd0, prod}, {24'd0, exp});
                end
            end
        end

        $display("[TB] W=8 regression");
        applyStimulusWide(8'h80, 8'h80, 1'b1, prod8, lat, busy_cnt);
        checkOutput("w8_s_80x80", {16'd0, prod8}, 32'h4000);
        checkOutput("w8_latency", lat, 9);
        checkOutput("w8_busy_cycles", busy_cnt, 9);
        checkOutput("w8_ready_back", {31'd0, in_ready8}, 32'd1);
        applyStimulusWide(8'hFF, 8'hFF, 1'b0, prod8, lat, busy_cnt);
        checkOutput("w8_u_FFxFF", {16'd0, prod8}, 32'hFE01);
        checkOutput("w8_latency_u", lat, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
